map_scheduler: RTL

MAP_SCHEDULER -- requirements
Module: map_scheduler

---
 rtl/map_scheduler.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/map_scheduler.sv
// map_scheduler: sequencing controller for a forward/backward MAP decoder pass.
// It runs an alpha (forward) recursion over L trellis steps and writes every
// step to the alpha buffer, then a beta (backward) recursion that reads the
// buffer in reverse while the LLR unit consumes it.
//
// Build option: MAP_SCHED_NORM_EN adds a per-pass advance counter that drives
// norm_pulse every NORM_PERIOD advancing steps. Without it, norm_pulse is 0.
//
// state  | meaning
// IDLE   | waiting for start; rejects out-of-range frame lengths with err
// INIT_F | one-cycle alpha recursion initialise, k cleared
// FWD    | one alpha step per en cycle, alpha written to buffer at k
// INIT_B | one-cycle beta recursion initialise, k loaded with L-1
// BWD    | one beta/LLR step per en cycle, alpha read back from k
// DONE   | one-cycle frame-complete pulse
module map_scheduler #(
  parameter int K           = 64,
  parameter int AW          = 6,
  parameter int NORM_PERIOD = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          en,
  input  logic          abort,
  input  logic [AW:0]   frame_len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          alpha_init,
  output logic          beta_init,
  output logic          alpha_en,
  output logic          beta_en,
  output logic          llr_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic          norm_pulse
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_F,
    S_FWD,
    S_INIT_B,
    S_BWD,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] addr_q;
  logic [AW:0]   len_q, len_d;
  logic [AW:0]   len_m1;
  logic          len_ok;
  logic          last_k;
  logic          step;

  assign len_ok = (frame_len != '0) && (frame_len <= (AW+1)'(K));
  assign len_m1 = len_q - (AW+1)'(1);
  assign last_k = ({1'b0, k_q} == len_m1);

  // State, step index, latched frame length and the held buffer address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      len_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
      addr_q  <= mem_addr;
    end
  end

  // Next-state and strobe decode; abort overrides everything outside IDLE.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    len_d      = len_q;
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    err        = 1'b0;
    alpha_init = 1'b0;
    beta_init  = 1'b0;
    alpha_en   = 1'b0;
    beta_en    = 1'b0;
    llr_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = addr_q;
    step       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d   = frame_len;
            state_d = S_INIT_F;
          end else begin
            err = 1'b1;
          end
        end
      end
      S_INIT_F: begin
        alpha_init = 1'b1;
        k_d        = '0;
        state_d    = S_FWD;
      end
      S_FWD: begin
        if (en) begin
          alpha_en = 1'b1;
          mem_we   = 1'b1;
          mem_addr = k_q;
          step     = 1'b1;
          if (last_k) state_d = S_INIT_B;
          else        k_d     = k_q + 1'b1;
        end
      end
      S_INIT_B: begin
        beta_init = 1'b1;
        k_d       = len_m1[AW-1:0];
        state_d   = S_BWD;
      end
      S_BWD: begin
        if (en) begin
          beta_en  = 1'b1;
          llr_en   = 1'b1;
          mem_addr = k_q;
          step     = 1'b1;
          if (k_q == '0) state_d = S_DONE;
          else           k_d     = k_q - 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      k_d        = k_q;
      done       = 1'b0;
      alpha_init = 1'b0;
      beta_init  = 1'b0;
      alpha_en   = 1'b0;
      beta_en    = 1'b0;
      llr_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = addr_q;
      step       = 1'b0;
    end
  end

`ifdef MAP_SCHED_NORM_EN
  localparam int CW = (NORM_PERIOD > 2) ? $clog2(NORM_PERIOD) : 1;
  logic [CW-1:0] c_q;

  // Advance counter, restarted at the top of each pass, wrapping every NORM_PERIOD steps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_q <= '0;
    end else if ((state_q == S_INIT_F) || (state_q == S_INIT_B)) begin
      c_q <= '0;
    end else if (step) begin
      c_q <= (c_q == CW'(NORM_PERIOD-1)) ? '0 : c_q + 1'b1;
    end
  end

  assign norm_pulse = step && (c_q == CW'(NORM_PERIOD-1));
`else
  assign norm_pulse = 1'b0;
`endif

endmodule
